// File: rtl/sched_pkg.sv
// Shared scheduler types and sizing constants for the task dispatch block.
package sched_pkg;

  localparam int NUM_CORES = 4;
  localparam int NUM_PRIO  = 4;
  localparam int PRIO_W    = 2;
  localparam int DUR_W     = 8;
  localparam int CORE_W    = 2;

  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [DUR_W-1:0]  duration;
  } task_t;

  // A zero-length task still occupies its core for one cycle.
  function automatic logic [DUR_W-1:0] run_time(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

endpackage

// File: rtl/prio_fifo.sv
// Synchronous FIFO holding the pending tasks of one priority level.
module prio_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/task_dispatch_controller.sv
// Priority task dispatcher: four priority FIFOs with aging, feeding four cores
// that each count down the remaining run time of their current task.
module task_dispatch_controller
  import sched_pkg::*;
#(
  parameter int QDEPTH    = 4,
  parameter int AGE_LIMIT = 8,
  localparam int LW       = $clog2(QDEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   task_valid,
  input  logic [PRIO_W-1:0]      task_priority,
  input  logic [DUR_W-1:0]       task_duration,
  output logic                   task_ready,
  output logic [NUM_CORES-1:0]   core_busy,
  output logic [DUR_W-1:0]       core_task_time_0,
  output logic [DUR_W-1:0]       core_task_time_1,
  output logic [DUR_W-1:0]       core_task_time_2,
  output logic [DUR_W-1:0]       core_task_time_3,
  output logic                   dispatch_valid,
  output logic [CORE_W-1:0]      dispatch_core,
  output logic [PRIO_W-1:0]      dispatch_prio,
  output logic [NUM_PRIO*LW-1:0] queue_level
);

  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  task_t               in_task;
  task_t               head [NUM_PRIO];
  task_t               grant_task;
  logic [NUM_PRIO-1:0] push;
  logic [NUM_PRIO-1:0] pop;
  logic [NUM_PRIO-1:0] full;
  logic [NUM_PRIO-1:0] empty;
  logic [LW-1:0]       level [NUM_PRIO];
  logic [AGE_W-1:0]    age [NUM_PRIO-1];
  logic [DUR_W-1:0]    core_time [NUM_CORES];
  logic                free_any;
  logic                grant_any;
  logic                do_dispatch;
  logic [CORE_W-1:0]   free_core;
  logic [PRIO_W-1:0]   grant_q;

  // Handshake: a task transfers at the rising edge where task_valid and
  // task_ready are both high; task_ready only depends on the target queue
  // being not full, never on a pop happening in the same cycle.
  assign in_task    = '{prio: task_priority, duration: task_duration};
  assign task_ready = !reset && !full[task_priority];

  for (genvar q = 0; q < NUM_PRIO; q++) begin : g_queue
    assign push[q] = task_valid && task_ready && (task_priority == PRIO_W'(q));
    assign pop[q]  = do_dispatch && (grant_q == PRIO_W'(q));

    prio_fifo #(
      .DEPTH (QDEPTH),
      .W     ($bits(task_t))
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[q]),
      .push_data (in_task),
      .pop       (pop[q]),
      .pop_data  (head[q]),
      .full      (full[q]),
      .empty     (empty[q]),
      .level     (level[q])
    );

    assign queue_level[q*LW +: LW] = level[q];
  end

  // Highest non-empty queue, overridden by the highest queue that has aged out.
  always_comb begin
    grant_any = 1'b0;
    grant_q   = '0;
    for (int q = 0; q < NUM_PRIO; q++) begin
      if (!empty[q]) begin
        grant_any = 1'b1;
        grant_q   = PRIO_W'(q);
      end
    end
    for (int q = 0; q < NUM_PRIO - 1; q++) begin
      if (!empty[q] && (age[q] == AGE_MAX)) begin
        grant_q = PRIO_W'(q);
      end
    end
  end

  always_comb begin
    free_any  = 1'b0;
    free_core = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (!core_busy[c]) begin
        free_any  = 1'b1;
        free_core = CORE_W'(c);
      end
    end
  end

  assign do_dispatch = free_any && grant_any;
  assign grant_task  = head[grant_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      core_busy      <= '0;
      dispatch_valid <= 1'b0;
      dispatch_core  <= '0;
      dispatch_prio  <= '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        core_time[c] <= '0;
      end
      for (int q = 0; q < NUM_PRIO - 1; q++) begin
        age[q] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (core_busy[c]) begin
          if (core_time[c] <= DUR_W'(1)) begin
            core_busy[c] <= 1'b0;
            core_time[c] <= '0;
          end else begin
            core_time[c] <= core_time[c] - 1'b1;
          end
        end
      end
      // The granted core was idle, so this never collides with the countdown.
      if (do_dispatch) begin
        core_busy[free_core] <= 1'b1;
        core_time[free_core] <= run_time(grant_task.duration);
        dispatch_core        <= free_core;
        dispatch_prio        <= grant_task.prio;
      end
      dispatch_valid <= do_dispatch;
      for (int q = 0; q < NUM_PRIO - 1; q++) begin
        if (empty[q] || (do_dispatch && (grant_q == PRIO_W'(q)))) begin
          age[q] <= '0;
        end else if (do_dispatch && (age[q] != AGE_MAX)) begin
          age[q] <= age[q] + 1'b1;
        end
      end
    end
  end

  assign core_task_time_0 = core_time[0];
  assign core_task_time_1 = core_time[1];
  assign core_task_time_2 = core_time[2];
  assign core_task_time_3 = core_time[3];

endmodule

// File: doc/task_dispatch_controller.md
TASK_DISPATCH_CONTROLLER -- requirements
Module: task_dispatch_controller

Interface
REQ-001 Parameter QDEPTH, default 4, entries per priority queue (power of 2, >=2).
REQ-002 Parameter AGE_LIMIT, default 8, waiting cycles before a queued lower-priority task is promoted.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 task_valid  input  1  incoming task present.
REQ-006 task_priority  input  2  task priority, 3 highest, 0 lowest.
REQ-007 task_duration  input  8  execution time in cycles.
REQ-008 task_ready  output  1  task accepted at this edge if task_valid also high.
REQ-009 core_busy  output  4  per-core busy flag.
REQ-010 core_task_time_0..3  output  8 each  remaining cycles per core.
REQ-011 dispatch_valid  output  1  one-cycle pulse on each task dispatch.
REQ-012 dispatch_core  output  2  core index of the current dispatch.
REQ-013 dispatch_prio  output  2  source queue of the current dispatch.
REQ-014 queue_level  output  4*(log2(QDEPTH)+1)  occupancy per queue, queue 0 in LSBs.

Function
REQ-015 task_ready shall equal NOT full of queue[task_priority], combinational; a full queue shall not accept, even when that queue dispatches in the same cycle.
REQ-016 An accepted task shall be enqueued FIFO-order into its priority queue and become dispatchable no earlier than the next cycle.
REQ-017 Each cycle, if any core_busy bit is 0 and any queue is non-empty (start-of-cycle state), exactly one task shall be dispatched.
REQ-018 Queue selection: the highest-priority queue whose age counter equals AGE_LIMIT; if none, the highest-priority non-empty queue.
REQ-019 Core selection: the lowest-index core with core_busy=0 at start of cycle.
REQ-020 On dispatch: core_busy[c] becomes 1 and core_task_time_c becomes max(duration,1) at the same edge; dispatch_valid/core/prio are registered and valid for that same following cycle.
REQ-021 A busy core with time >1 shall decrement by 1 per cycle; at time=1 the next edge clears busy and time to 0, so a task of duration D (D>=1) holds busy high for exactly D cycles.
REQ-022 A core freed at an edge shall be eligible for dispatch in the cycle following that edge.
REQ-023 Age counters exist for queues 0..2: increment (saturating at AGE_LIMIT) each cycle the queue is non-empty and a dispatch is granted to another queue; clear when the queue is granted or is empty.
REQ-024 Simultaneous enqueue and dispatch on one queue shall leave its level unchanged.
REQ-025 dispatch_valid shall be 0 in every cycle without a dispatch; dispatch_core/prio hold their last values.

Reset
REQ-026 While reset is high: task_ready=0; all queues empty; queue_level=0; core_busy=0; all core_task_time=0; age counters=0; dispatch_valid=0, dispatch_core=0, dispatch_prio=0.
REQ-027 Reset asserted mid-task shall discard all queued and running tasks; the first acceptance is possible in the first cycle after reset deasserts.

Structure
REQ-028 Shared package sched_pkg shall hold NUM_CORES=4, NUM_PRIO=4, PRIO_W=2, DUR_W=8, and a task typedef {priority, duration}.
REQ-029 One sub-module prio_fifo (synchronous FIFO, depth QDEPTH, full/empty/level outputs) shall be instantiated once per priority.

Verification
REQ-030 After reset, push prio 1 dur 3 -> dispatch_valid with core 0, prio 1; core_busy[0] high exactly 3 cycles, time 3,2,1.
REQ-031 Push prio 0 dur 5 and prio 3 dur 5 in consecutive cycles while all cores busy; free one core -> prio 3 dispatched first.
REQ-032 All cores busy, push 4 tasks prio 2 -> queue_level[2]=4, task_ready=0 for prio 2; 5th push not accepted; prio 1 still accepted.
REQ-033 Aging: AGE_LIMIT=8, one prio-0 task queued, continuous prio-3 stream -> prio-0 task dispatched on the grant after 8 cycles of being passed over.
REQ-034 Push dur 0 -> core busy exactly 1 cycle; cores 0..3 free and 4 tasks queued -> dispatch to cores 0,1,2,3 on consecutive cycles.
REQ-035 Reset asserted while 3 cores busy and queues non-empty -> all outputs match REQ-026 on the next cycle.
